unidade_controle: RTL and testbench
===================================

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 SHALL have parameter LARGURA_CONT, default 32: width of the retired-instruction counter.
REQ-002 SHALL have parameter OPCODE_PARADA, default 7'b0000000: opcode that halts the datapath.
REQ-003 SHALL have these ports:
- clk  in  1  sole clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  7  instruction[6:0], sampled in DECODIFICA
- funct3  in  3  instruction[14:12]
- zero  in  1  ALU zero flag, valid in DESVIO
- mem_pronta  in  1  data-memory completion handshake
- estado  out  4  current state code, drives registradores.estado
- regiwrite  out  1  register-file write enable
- memtoreg  out  1  1 = write reddataM, 0 = write aluresult2
- memread, memwrite  out  1 each  data-memory strobes
- irwrite, pcwrite, alusrc  out  1 each  IR load, PC update, ALU B = immediate
- aluop  out  2  00 add, 01 sub (branch compare), 10 funct-decoded
- pc_desvio  out  1  1 = PC takes branch target
- erro  out  1  sticky illegal-opcode flag
- contador_instr  out  LARGURA_CONT  retired-instruction count

Function
REQ-004 SHALL be a Moore FSM; outputs are decoded from the registered estado only.
REQ-005 SHALL use these state codes: BUSCA 0000, DECODIFICA 0001, EXEC_R 0010, CALC_END 0011, ACESSO_MEM 0100, ESCRITA_LOAD 0101, EXEC_I 0110, DESVIO 0111, ESCRITA_MEM 1000, PARADA 1111.
REQ-006 SHALL make these transitions:
- BUSCA -> DECODIFICA
- DECODIFICA by opcode: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011 or 0100011 -> CALC_END; 1100011 -> DESVIO; OPCODE_PARADA -> PARADA; other -> per REQ-015
- CALC_END -> ACESSO_MEM (load) or ESCRITA_MEM (store)
- ACESSO_MEM and ESCRITA_MEM hold until mem_pronta = 1; then ACESSO_MEM -> ESCRITA_LOAD and ESCRITA_MEM -> BUSCA
- EXEC_R, EXEC_I, ESCRITA_LOAD, DESVIO -> BUSCA
- PARADA holds until reset
REQ-007 SHALL assert regiwrite only in EXEC_R, EXEC_I and ESCRITA_LOAD; it SHALL be 0 in DESVIO, even though the register file is active in that state.
REQ-008 SHALL assert memtoreg only in ESCRITA_LOAD.
REQ-009 SHALL assert irwrite and pcwrite in BUSCA; pcwrite also in DESVIO.
REQ-010 SHALL assert memread in ACESSO_MEM and memwrite in ESCRITA_MEM, held for every wait cycle.
REQ-011 SHALL set alusrc = 1 in EXEC_I and CALC_END; aluop = 10 in EXEC_R and EXEC_I, 01 in DESVIO, 00 elsewhere.
REQ-012 SHALL set pc_desvio in DESVIO to zero when funct3 = 000 (beq), to ~zero when funct3 = 001 (bne), and to 0 for other funct3 values.
REQ-013 SHALL increment contador_instr by 1 on each transition into BUSCA from a non-BUSCA, non-reset state; the counter wraps at 2^LARGURA_CONT modulo.
REQ-014 SHALL give these latencies: R/I/branch 3 cycles, store 4 + waits, load 5 + waits; a mem_pronta already high on entry adds no wait.

Reset
REQ-016 SHALL, on reset (asynchronous, mid-operation included), force estado = BUSCA, contador_instr = 0 and erro = 0; all strobes follow BUSCA decode (irwrite = pcwrite = 1, all other strobes 0).
REQ-017 SHALL abort an in-progress memory wait on reset without asserting a further memread or memwrite.

Configuration
REQ-015 SHALL, with ILEGAL_PARADA_EN defined, send an unknown opcode to PARADA and set erro; without it, send an unknown opcode to BUSCA as a NOP (counted as retired) and keep erro at 0.

Structure
REQ-018 SHALL place the state codes, opcode constants and aluop codes in the shared package riscv_pkg, which also serves registradores and the ALU control.
REQ-019 SHALL put the next-state logic and output decode in unidade_controle; the only sub-module SHALL be decod_saidas (purely combinational estado -> strobes).

Verification
REQ-020 SHALL cover: R-type add, opcode 0110011 -> estado 0000, 0001, 0010, 0000; regiwrite = 1 only in 0010; count +1.
REQ-021 SHALL cover: load with mem_pronta low for 3 cycles -> ACESSO_MEM held 4 cycles with memread = 1; then 0101 with regiwrite = memtoreg = 1; 8 cycles total.
REQ-022 SHALL cover: beq with zero = 1 -> pc_desvio = 1, pcwrite = 1, regiwrite = 0; bne with zero = 1 -> pc_desvio = 0.
REQ-023 SHALL cover: opcode 1111111 -> PARADA with erro = 1 (macro defined); BUSCA with count +1 (macro undefined).
REQ-024 SHALL cover: reset asserted during ESCRITA_MEM wait -> immediate estado 0000, memwrite = 0, contador_instr = 0.
REQ-025 SHALL cover: LARGURA_CONT = 4, 16 retired NOP-class instructions -> contador_instr wraps to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the multicycle RISC-V control path.
// Holds the FSM state codes, the decoded opcodes, the aluop encodings and the
// branch funct3 codes. It is also used by registradores and the ALU control.
package riscv_pkg;

    typedef enum logic [3:0] {
        BUSCA        = 4'b0000,
        DECODIFICA   = 4'b0001,
        EXEC_R       = 4'b0010,
        CALC_END     = 4'b0011,
        ACESSO_MEM   = 4'b0100,
        ESCRITA_LOAD = 4'b0101,
        EXEC_I       = 4'b0110,
        DESVIO       = 4'b0111,
        ESCRITA_MEM  = 4'b1000,
        PARADA       = 4'b1111
    } estado_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/decod_saidas.sv
// decod_saidas: purely combinational decode of the registered state code
// into the datapath strobes. Branch selection (pc_desvio) is not handled
// here because it also depends on zero/funct3.
module decod_saidas
    import riscv_pkg::*;
(
    input  logic [3:0] estado,
    output logic       regiwrite,
    output logic       memtoreg,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       alusrc,
    output logic [1:0] aluop
);

    // State code to strobes; every strobe defaults low, aluop defaults to add.
    always_comb begin
        regiwrite = 1'b0;
        memtoreg  = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        pcwrite   = 1'b0;
        alusrc    = 1'b0;
        aluop     = ALUOP_ADD;
        case (estado)
            BUSCA: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
            end
            EXEC_R: begin
                regiwrite = 1'b1;
                aluop     = ALUOP_FUNCT;
            end
            EXEC_I: begin
                regiwrite = 1'b1;
                alusrc    = 1'b1;
                aluop     = ALUOP_FUNCT;
            end
            CALC_END: begin
                alusrc = 1'b1;
            end
            ACESSO_MEM: begin
                memread = 1'b1;
            end
            ESCRITA_LOAD: begin
                regiwrite = 1'b1;
                memtoreg  = 1'b1;
            end
            ESCRITA_MEM: begin
                memwrite = 1'b1;
            end
            // The register file reads operands here, but nothing is written back.
            DESVIO: begin
                pcwrite = 1'b1;
                aluop   = ALUOP_SUB;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: Moore FSM control unit of the multicycle RISC-V core.
// Optional build macro ILEGAL_PARADA_EN: when defined, an unknown opcode halts
// the core in PARADA and sets the sticky erro flag; when undefined, an unknown
// opcode retires as a NOP and erro stays 0.
module unidade_controle
    import riscv_pkg::*;
#(
    parameter int         LARGURA_CONT  = 32,
    parameter logic [6:0] OPCODE_PARADA = 7'b0000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              opcode,
    input  logic [2:0]              funct3,
    input  logic                    zero,
    input  logic                    mem_pronta,
    output logic [3:0]              estado,
    output logic                    regiwrite,
    output logic                    memtoreg,
    output logic                    memread,
    output logic                    memwrite,
    output logic                    irwrite,
    output logic                    pcwrite,
    output logic                    alusrc,
    output logic [1:0]              aluop,
    output logic                    pc_desvio,
    output logic                    erro,
    output logic [LARGURA_CONT-1:0] contador_instr
);

    estado_t                 estado_q;
    estado_t                 estado_d;
    logic                    eh_load_q;
    logic                    erro_q;
    logic                    erro_set;
    logic                    retira;
    logic [LARGURA_CONT-1:0] contador_q;

    // Next-state decode; opcode only matters in DECODIFICA.
    always_comb begin
        estado_d = estado_q;
        erro_set = 1'b0;
        case (estado_q)
            BUSCA:      estado_d = DECODIFICA;
            DECODIFICA: begin
                if (opcode == OP_R)
                    estado_d = EXEC_R;
                else if (opcode == OP_I)
                    estado_d = EXEC_I;
                else if ((opcode == OP_LOAD) || (opcode == OP_STORE))
                    estado_d = CALC_END;
                else if (opcode == OP_BRANCH)
                    estado_d = DESVIO;
                else if (opcode == OPCODE_PARADA)
                    estado_d = PARADA;
                else begin
`ifdef ILEGAL_PARADA_EN
                    estado_d = PARADA;
                    erro_set = 1'b1;
`else
                    estado_d = BUSCA;
`endif
                end
            end
            CALC_END:     estado_d = eh_load_q ? ACESSO_MEM : ESCRITA_MEM;
            ACESSO_MEM:   estado_d = mem_pronta ? ESCRITA_LOAD : ACESSO_MEM;
            ESCRITA_MEM:  estado_d = mem_pronta ? BUSCA : ESCRITA_MEM;
            EXEC_R, EXEC_I, ESCRITA_LOAD, DESVIO: estado_d = BUSCA;
            PARADA:       estado_d = PARADA;
            default:      estado_d = BUSCA;
        endcase
    end

    // An instruction retires whenever the FSM re-enters BUSCA from elsewhere.
    assign retira = (estado_q != BUSCA) && (estado_d == BUSCA);

    // State, load/store selector, sticky error and retired counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q   <= BUSCA;
            eh_load_q  <= 1'b0;
            erro_q     <= 1'b0;
            contador_q <= '0;
        end else begin
            estado_q <= estado_d;
            // CALC_END sees a new opcode on the bus, so remember load vs store.
            if (estado_q == DECODIFICA)
                eh_load_q <= (opcode == OP_LOAD);
            if (erro_set)
                erro_q <= 1'b1;
            if (retira)
                contador_q <= contador_q + LARGURA_CONT'(1);
        end
    end

    decod_saidas u_decod_saidas (
        .estado    (estado_q),
        .regiwrite (regiwrite),
        .memtoreg  (memtoreg),
        .memread   (memread),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .pcwrite   (pcwrite),
        .alusrc    (alusrc),
        .aluop     (aluop)
    );

    // Branch target selection: beq takes on zero, bne on not-zero, others never.
    always_comb begin
        pc_desvio = 1'b0;
        if (estado_q == DESVIO) begin
            if (funct3 == F3_BEQ)
                pc_desvio = zero;
            else if (funct3 == F3_BNE)
                pc_desvio = ~zero;
        end
    end

    assign estado         = estado_q;
    assign erro           = erro_q;
    assign contador_instr = contador_q;

endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: scoreboard bench for unidade_controle (LARGURA_CONT = 4).
// The stimulus side walks instruction by instruction, deriving the expected
// per-cycle observation from the instruction class; a negedge monitor pops and
// compares one observation per clock.
module tb_unidade_controle;

    localparam int W = 4;

    localparam logic [3:0] S_BUSCA  = 4'b0000;
    localparam logic [3:0] S_DECOD  = 4'b0001;
    localparam logic [3:0] S_EXEC_R = 4'b0010;
    localparam logic [3:0] S_CALC   = 4'b0011;
    localparam logic [3:0] S_ACESSO = 4'b0100;
    localparam logic [3:0] S_ESC_LD = 4'b0101;
    localparam logic [3:0] S_EXEC_I = 4'b0110;
    localparam logic [3:0] S_DESVIO = 4'b0111;
    localparam logic [3:0] S_ESC_MEM= 4'b1000;
    localparam logic [3:0] S_PARADA = 4'b1111;

    typedef enum int {C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_HALT, C_ILEGAL} classe_t;

    typedef struct packed {
        logic [3:0]   estado;
        logic         regiwrite;
        logic         memtoreg;
        logic         memread;
        logic         memwrite;
        logic         irwrite;
        logic         pcwrite;
        logic         alusrc;
        logic [1:0]   aluop;
        logic         pc_desvio;
        logic         erro;
        logic [W-1:0] cnt;
    } obs_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic         zero;
    logic         mem_pronta;
    logic [3:0]   estado;
    logic         regiwrite, memtoreg, memread, memwrite;
    logic         irwrite, pcwrite, alusrc, pc_desvio, erro;
    logic [1:0]   aluop;
    logic [W-1:0] contador_instr;

    obs_t sb[$];
    bit   running = 0;
    int   nvec = 0;
    int   nmis = 0;
    int   retired = 0;
    bit   erro_m = 0;

    always #5 clk = ~clk;

    unidade_controle #(.LARGURA_CONT(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .opcode         (opcode),
        .funct3         (funct3),
        .zero           (zero),
        .mem_pronta     (mem_pronta),
        .estado         (estado),
        .regiwrite      (regiwrite),
        .memtoreg       (memtoreg),
        .memread        (memread),
        .memwrite       (memwrite),
        .irwrite        (irwrite),
        .pcwrite        (pcwrite),
        .alusrc         (alusrc),
        .aluop          (aluop),
        .pc_desvio      (pc_desvio),
        .erro           (erro),
        .contador_instr (contador_instr)
    );

    // Expected observation for one cycle spent in state st.
    function automatic obs_t modelo(input logic [3:0] st, input logic z, input logic [2:0] f3);
        obs_t o;
        o           = '0;
        o.estado    = st;
        o.regiwrite = (st == S_EXEC_R) || (st == S_EXEC_I) || (st == S_ESC_LD);
        o.memtoreg  = (st == S_ESC_LD);
        o.memread   = (st == S_ACESSO);
        o.memwrite  = (st == S_ESC_MEM);
        o.irwrite   = (st == S_BUSCA);
        o.pcwrite   = (st == S_BUSCA) || (st == S_DESVIO);
        o.alusrc    = (st == S_EXEC_I) || (st == S_CALC);
        o.aluop     = ((st == S_EXEC_R) || (st == S_EXEC_I)) ? 2'b10 :
                      (st == S_DESVIO) ? 2'b01 : 2'b00;
        o.pc_desvio = (st == S_DESVIO) && (((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z));
        o.erro      = erro_m;
        o.cnt       = W'(retired % (1 << W));
        return o;
    endfunction

    function automatic classe_t classifica(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b1100011: return C_BRANCH;
            7'b0000000: return C_HALT;
            default:    return C_ILEGAL;
        endcase
    endfunction

    // One clock of stimulus: drive inputs, push the expectation, advance.
    task automatic cyc(input logic [3:0] st, input logic [6:0] op, input logic mp,
                       input logic z, input logic [2:0] f3, input logic rst_v);
        opcode     = op;
        mem_pronta = mp;
        zero       = z;
        funct3     = f3;
        reset      = rst_v;
        sb.push_back(modelo(st, z, f3));
        running = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_rnd(input logic [3:0] st);
        cyc(st, 7'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 1'b0);
    endtask

    task automatic cyc_mem(input logic [3:0] st, input logic mp);
        cyc(st, 7'($urandom), mp, 1'($urandom), 3'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        retired = 0;
        erro_m  = 0;
        cyc(S_BUSCA, 7'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 1'b1);
    endtask

    // Whole instruction; abort_at >= 0 asserts reset at that memory wait cycle.
    task automatic instr(input logic [6:0] op, input int waits, input logic z,
                         input logic [2:0] f3, input int abort_at, input int halt_cycles);
        classe_t c;
        c = classifica(op);
        cyc_rnd(S_BUSCA);
        cyc(S_DECOD, op, 1'($urandom), 1'($urandom), 3'($urandom), 1'b0);
        case (c)
            C_R:      begin cyc_rnd(S_EXEC_R); retired++; end
            C_I:      begin cyc_rnd(S_EXEC_I); retired++; end
            C_BRANCH: begin
                cyc(S_DESVIO, 7'($urandom), 1'($urandom), z, f3, 1'b0);
                retired++;
            end
            C_LOAD, C_STORE: begin
                logic [3:0] sm;
                sm = (c == C_LOAD) ? S_ACESSO : S_ESC_MEM;
                cyc_rnd(S_CALC);
                for (int i = 0; i < waits; i++) begin
                    if (i == abort_at) begin
                        do_reset();
                        return;
                    end
                    cyc_mem(sm, 1'b0);
                end
                cyc_mem(sm, 1'b1);
                if (c == C_LOAD) cyc_rnd(S_ESC_LD);
                retired++;
            end
            C_HALT: begin
                for (int i = 0; i < halt_cycles; i++) cyc_rnd(S_PARADA);
                do_reset();
            end
            default: begin
`ifdef ILEGAL_PARADA_EN
                erro_m = 1;
                for (int i = 0; i < halt_cycles; i++) cyc_rnd(S_PARADA);
                do_reset();
`else
                retired++;
`endif
            end
        endcase
    endtask

    function automatic logic [6:0] op_aleatorio();
        int r;
        logic [6:0] o;
        r = int'($urandom_range(0, 99));
        if (r < 20)      return 7'b0110011;
        else if (r < 35) return 7'b0010011;
        else if (r < 50) return 7'b0000011;
        else if (r < 65) return 7'b0100011;
        else if (r < 80) return 7'b1100011;
        else if (r < 85) return 7'b0000000;
        for (int k = 0; k < 20; k++) begin
            o = 7'($urandom);
            if (classifica(o) == C_ILEGAL) return o;
        end
        return 7'b1111111;
    endfunction

    // Monitor: one comparison per clock, sampled on the falling edge.
    always @(negedge clk) begin
        if (running) begin
            obs_t a, e;
            a.estado    = estado;
            a.regiwrite = regiwrite;
            a.memtoreg  = memtoreg;
            a.memread   = memread;
            a.memwrite  = memwrite;
            a.irwrite   = irwrite;
            a.pcwrite   = pcwrite;
            a.alusrc    = alusrc;
            a.aluop     = aluop;
            a.pc_desvio = pc_desvio;
            a.erro      = erro;
            a.cnt       = contador_instr;
            nvec++;
            if (sb.size() == 0) begin
                nmis++;
                $display("FAIL underflow vec %0d: got %b, no expectation queued", nvec, a);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    nmis++;
                    $display("FAIL vec %0d t=%0t: got estado=%h rw=%b m2r=%b mr=%b mw=%b ir=%b pc=%b as=%b aluop=%b pcd=%b erro=%b cnt=%0d; expected estado=%h rw=%b m2r=%b mr=%b mw=%b ir=%b pc=%b as=%b aluop=%b pcd=%b erro=%b cnt=%0d",
                             nvec, $time, a.estado, a.regiwrite, a.memtoreg, a.memread, a.memwrite, a.irwrite,
                             a.pcwrite, a.alusrc, a.aluop, a.pc_desvio, a.erro, a.cnt,
                             e.estado, e.regiwrite, e.memtoreg, e.memread, e.memwrite, e.irwrite,
                             e.pcwrite, e.alusrc, e.aluop, e.pc_desvio, e.erro, e.cnt);
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        opcode     = '0;
        funct3     = '0;
        zero       = 1'b0;
        mem_pronta = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Directed scenarios first.
        instr(7'b0110011, 0, 1'b0, 3'd0, -1, 0);   // R-type add
        instr(7'b0000011, 3, 1'b0, 3'd0, -1, 0);   // load, three wait cycles
        instr(7'b1100011, 0, 1'b1, 3'd0, -1, 0);   // beq, zero=1 -> taken
        instr(7'b1100011, 0, 1'b1, 3'd1, -1, 0);   // bne, zero=1 -> not taken
        instr(7'b1100011, 0, 1'b0, 3'd5, -1, 0);   // other funct3 -> never taken
        instr(7'b0100011, 0, 1'b0, 3'd0, -1, 0);   // store, ready on entry
        instr(7'b1111111, 0, 1'b0, 3'd0, -1, 3);   // illegal opcode
        instr(7'b0100011, 3, 1'b0, 3'd0,  1, 0);   // store aborted by reset mid-wait
        for (int i = 0; i < 17; i++)
            instr(7'b0110011, 0, 1'b0, 3'd0, -1, 0); // counter wraps past 15
        instr(7'b0000000, 0, 1'b0, 3'd0, -1, 2);   // halt opcode

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            int         w, ab;
            logic [2:0] f3;
            op = op_aleatorio();
            w  = int'($urandom_range(0, 4));
            ab = ((w > 0) && ($urandom_range(0, 99) < 15)) ? int'($urandom_range(0, w - 1)) : -1;
            f3 = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 1)) : 3'($urandom);
            instr(op, w, 1'($urandom), f3, ab, int'($urandom_range(1, 4)));
        end

        running = 0;
        if (sb.size() != 0) begin
            nmis++;
            $display("FAIL leftover: %0d expectations never observed, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
